uart_cmd_parser: RTL and testbench

//  Sits directly downstream of the UART receiver in the SDRAM test path. Consumes received

---
 rtl/uart_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles 8-byte UART command frames into SDRAM read/write requests
//
// Frame: SOF, CMD, ADDR[23:16], ADDR[15:8], ADDR[7:0], WD[15:8], WD[7:0], CHK
// CHK is the XOR of CMD..WD[7:0]. Good frames are presented on a valid/ready port.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   rx_data, rx_valid, rx_parity_err   byte stream from the UART receiver
//   cmd_valid, cmd_ready               command handshake
//   cmd_wr, cmd_addr, cmd_wdata        command payload (held while cmd_valid)
//   err_par_o, err_cmd_o, err_chk_o,
//   err_tmo_o, err_ovf_o               single-cycle error pulses
module uart_cmd_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_parity_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_wr,
    output logic [23:0] cmd_addr,
    output logic [15:0] cmd_wdata,
    output logic        err_par_o,
    output logic        err_cmd_o,
    output logic        err_chk_o,
    output logic        err_tmo_o,
    output logic        err_ovf_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t         state;
    logic [1:0]     idx;
    logic [TW-1:0]  tmo_cnt;
    logic [7:0]     chk_acc;
    logic           wr_q;
    logic [23:0]    addr_q;
    logic [15:0]    wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            tmo_cnt   <= '0;
            chk_acc   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cmd_valid <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            err_par_o <= 1'b0;
            err_cmd_o <= 1'b0;
            err_chk_o <= 1'b0;
            err_tmo_o <= 1'b0;
            err_ovf_o <= 1'b0;
        end else begin
            err_par_o <= 1'b0;
            err_cmd_o <= 1'b0;
            err_chk_o <= 1'b0;
            err_tmo_o <= 1'b0;
            err_ovf_o <= 1'b0;

            // Handshake completion; a command loading in this same cycle overrides it below.
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (rx_valid) begin
                // A byte arriving on the last allowed cycle beats the timeout.
                tmo_cnt <= '0;
                if (state == S_IDLE) begin
                    // Anything other than a clean SOF is line noise while idle.
                    if (rx_data == SOF_BYTE && !rx_parity_err) begin
                        state <= S_CMD;
                    end
                end else if (rx_parity_err) begin
                    err_par_o <= 1'b1;
                    state     <= S_IDLE;
                end else begin
                    case (state)
                        S_CMD: begin
                            if (rx_data == 8'h01 || rx_data == 8'h02) begin
                                wr_q    <= (rx_data == 8'h01);
                                chk_acc <= rx_data;
                                idx     <= '0;
                                state   <= S_ADDR;
                            end else begin
                                err_cmd_o <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                        S_ADDR: begin
                            addr_q  <= {addr_q[15:0], rx_data};
                            chk_acc <= chk_acc ^ rx_data;
                            if (idx == 2'd2) begin
                                idx   <= '0;
                                state <= S_DATA;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                        S_DATA: begin
                            wdata_q <= {wdata_q[7:0], rx_data};
                            chk_acc <= chk_acc ^ rx_data;
                            if (idx == 2'd1) begin
                                idx   <= '0;
                                state <= S_CHK;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                        S_CHK: begin
                            state <= S_IDLE;
                            if (rx_data != chk_acc) begin
                                err_chk_o <= 1'b1;
                            end else if (cmd_valid && !cmd_ready) begin
                                // Consumer still holds the previous command: keep it, drop this one.
                                err_ovf_o <= 1'b1;
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_wr    <= wr_q;
                                cmd_addr  <= addr_q;
                                cmd_wdata <= wdata_q;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end else if (state != S_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    err_tmo_o <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_parity_err = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_wr;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        err_par_o, err_cmd_o, err_chk_o, err_tmo_o, err_ovf_o;

    uart_cmd_parser dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .err_par_o(err_par_o), .err_cmd_o(err_cmd_o), .err_chk_o(err_chk_o),
        .err_tmo_o(err_tmo_o), .err_ovf_o(err_ovf_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_par = 0, n_cmd = 0, n_chk = 0, n_tmo = 0, n_ovf = 0, n_acc = 0;
    int s_par, s_cmd, s_chk, s_tmo, s_ovf, s_acc;

    logic [7:0] fr[8];
    logic       fp[8];

    // Event counters sampled mid-cycle; a pulse longer than one cycle counts twice.
    always @(negedge clk) begin
        if (rst_n) begin
            n_par += int'(err_par_o);
            n_cmd += int'(err_cmd_o);
            n_chk += int'(err_chk_o);
            n_tmo += int'(err_tmo_o);
            n_ovf += int'(err_ovf_o);
            n_acc += int'(cmd_valid && cmd_ready);
        end
    end

    task automatic snap();
        s_par = n_par; s_cmd = n_cmd; s_chk = n_chk;
        s_tmo = n_tmo; s_ovf = n_ovf; s_acc = n_acc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p);
        rx_data = b;
        rx_parity_err = p;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    // Frame builder: checksum from the XOR rule over CMD..WD[7:0].
    task automatic mk_frame(input logic [7:0] c, input logic [23:0] a, input logic [15:0] d);
        fr[0] = 8'hA5; fr[1] = c;
        fr[2] = a[23:16]; fr[3] = a[15:8]; fr[4] = a[7:0];
        fr[5] = d[15:8]; fr[6] = d[7:0];
        fr[7] = 8'h00;
        for (int i = 1; i < 7; i++) fr[7] = fr[7] ^ fr[i];
        for (int i = 0; i < 8; i++) fp[i] = 1'b0;
    endtask

    task automatic send_fr(input int last, input int max_gap);
        for (int i = 0; i <= last; i++) begin
            send_byte(fr[i], fp[i]);
            if (max_gap > 0 && i != last) idle($urandom_range(max_gap, 0));
        end
    endtask

    // Reference: walk the frame by position. kind 0=good,1=parity,2=cmd,3=chk; at = last byte consumed.
    function automatic int model(output int at, output logic [40:0] pay);
        logic [7:0] x;
        pay = {fr[1] == 8'h01, fr[2], fr[3], fr[4], fr[5], fr[6]};
        for (int i = 1; i < 8; i++) begin
            at = i;
            if (fp[i]) return 1;
            if (i == 1 && fr[1] != 8'h01 && fr[1] != 8'h02) return 2;
            if (i == 7) begin
                x = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5] ^ fr[6];
                if (fr[7] != x) return 3;
            end
        end
        at = 7;
        return 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata, err_par_o, err_cmd_o, err_chk_o, err_tmo_o, err_ovf_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: got valid=%0b addr=%h wdata=%h, want all 0", cmd_valid, cmd_addr, cmd_wdata);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        snap();
        cmd_ready = 1'b0;
        mk_frame(8'h01, 24'h123456, 16'hBEEF);
        send_fr(7, 0);
        checks++;
        if (cmd_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %0b want 1", cmd_valid); end
        checks++;
        if ({cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 24'h123456, 16'hBEEF}) begin
            errors++; $display("FAIL wr_payload: got %0b %h %h want 1 123456 beef", cmd_wr, cmd_addr, cmd_wdata);
        end
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        idle(1);
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL wr_clear: got %0b want 0", cmd_valid); end
        checks++;
        if (n_acc - s_acc !== 1) begin errors++; $display("FAIL wr_accepts: got %0d want 1", n_acc - s_acc); end
    endtask

    task automatic test_read_hold();
        int bad;
        snap();
        bad = 0;
        cmd_ready = 1'b0;
        mk_frame(8'h02, 24'h000010, 16'h0000);
        send_fr(7, 0);
        for (int i = 0; i < 50; i++) begin
            if (cmd_valid !== 1'b1 || {cmd_wr, cmd_addr} !== {1'b0, 24'h000010}) bad++;
            idle(1);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rd_hold: got %0d unstable cycles want 0", bad); end
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        idle(3);
        checks++;
        if (n_acc - s_acc !== 1) begin errors++; $display("FAIL rd_fire_once: got %0d want 1", n_acc - s_acc); end
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rd_clear: got %0b want 0", cmd_valid); end
    endtask

    task automatic test_bad_chk();
        snap();
        cmd_ready = 1'b1;
        mk_frame(8'h01, 24'h123456, 16'hBEEF);
        fr[7] = fr[7] ^ 8'h01;
        send_fr(7, 0);
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL chk_no_valid: got %0b want 0", cmd_valid); end
        idle(2);
        checks++;
        if (n_chk - s_chk !== 1) begin errors++; $display("FAIL chk_pulse: got %0d want 1", n_chk - s_chk); end
        mk_frame(8'h02, 24'hABCDEF, 16'h1234);
        send_fr(7, 0);
        checks++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 1'b0, 24'hABCDEF, 16'h1234}) begin
            errors++; $display("FAIL chk_recover: got %0b %0b %h %h want 1 0 abcdef 1234", cmd_valid, cmd_wr, cmd_addr, cmd_wdata);
        end
        idle(2);
        cmd_ready = 1'b0;
    endtask

    task automatic test_bad_cmd_parity();
        snap();
        cmd_ready = 1'b1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        idle(2);
        checks++;
        if (n_cmd - s_cmd !== 1) begin errors++; $display("FAIL cmd_pulse: got %0d want 1", n_cmd - s_cmd); end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b1);
        idle(2);
        checks++;
        if (n_par - s_par !== 1) begin errors++; $display("FAIL par_pulse: got %0d want 1", n_par - s_par); end
        checks++;
        if (n_acc - s_acc !== 0 || n_cmd - s_cmd !== 1) begin
            errors++; $display("FAIL cmdpar_side: got acc=%0d cmd=%0d want 0 1", n_acc - s_acc, n_cmd - s_cmd);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_timeout();
        snap();
        cmd_ready = 1'b0;
        mk_frame(8'h01, 24'h123456, 16'h5A5A);
        send_fr(2, 0);
        idle(4399);
        send_fr(-1, 0);
        for (int i = 3; i < 8; i++) send_byte(fr[i], 1'b0);
        checks++;
        if ({cmd_valid, cmd_addr, cmd_wdata} !== {1'b1, 24'h123456, 16'h5A5A}) begin
            errors++; $display("FAIL tmo_edge_byte: got %0b %h %h want 1 123456 5a5a", cmd_valid, cmd_addr, cmd_wdata);
        end
        cmd_ready = 1'b1;
        idle(2);
        cmd_ready = 1'b0;
        checks++;
        if (n_tmo - s_tmo !== 0) begin errors++; $display("FAIL tmo_edge_none: got %0d want 0", n_tmo - s_tmo); end
        send_fr(2, 0);
        idle(4410);
        checks++;
        if (n_tmo - s_tmo !== 1) begin errors++; $display("FAIL tmo_pulse: got %0d want 1", n_tmo - s_tmo); end
        // Remaining bytes after the timeout must be ignored by an idle parser.
        for (int i = 3; i < 8; i++) send_byte(fr[i], 1'b0);
        idle(2);
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %0b want 0", cmd_valid); end
    endtask

    task automatic test_back_to_back();
        snap();
        cmd_ready = 1'b0;
        mk_frame(8'h01, 24'h0000AA, 16'h1111);
        send_fr(7, 0);
        mk_frame(8'h02, 24'h0000BB, 16'h2222);
        send_fr(7, 0);
        idle(2);
        checks++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 24'h0000AA, 16'h1111}) begin
            errors++; $display("FAIL ovf_keep: got %0b %0b %h %h want 1 1 0000aa 1111", cmd_valid, cmd_wr, cmd_addr, cmd_wdata);
        end
        checks++;
        if (n_ovf - s_ovf !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf - s_ovf); end
        cmd_ready = 1'b1;
        idle(2);
        snap();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b1);
        mk_frame(8'h01, 24'hFEDCBA, 16'h9876);
        send_fr(7, 0);
        idle(2);
        checks++;
        if ((n_par - s_par) + (n_cmd - s_cmd) + (n_chk - s_chk) + (n_tmo - s_tmo) + (n_ovf - s_ovf) !== 0 || n_acc - s_acc !== 1) begin
            errors++; $display("FAIL stray_ignore: got acc=%0d par=%0d want acc=1 no errors", n_acc - s_acc, n_par - s_par);
        end
        cmd_ready = 1'b0;
        mk_frame(8'h01, 24'h000001, 16'h0001);
        send_fr(7, 0);
        send_fr(3, 0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({cmd_valid, cmd_wr, cmd_addr, cmd_wdata} !== '0) begin
            errors++; $display("FAIL rst_mid: got %0b %h %h want all 0", cmd_valid, cmd_addr, cmd_wdata);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        // Tail of the interrupted frame is noise to a freshly reset parser.
        for (int i = 4; i < 8; i++) send_byte(fr[i], 1'b0);
        idle(2);
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_tail: got %0b want 0", cmd_valid); end
    endtask

    task automatic test_random();
        int kind, at, got;
        int bad;
        logic [40:0] pay;
        bad = 0;
        cmd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            mk_frame($urandom_range(1, 0) ? 8'h01 : 8'h02, 24'($urandom), 16'($urandom));
            kind = $urandom_range(3, 0);
            if (kind == 1) fp[$urandom_range(7, 1)] = 1'b1;
            if (kind == 2) fr[1] = 8'($urandom_range(255, 3));
            if (kind == 3) fr[7] = fr[7] ^ 8'($urandom_range(255, 1));
            kind = model(at, pay);
            snap();
            send_fr(at, 3);
            if (kind == 0) begin
                if (cmd_valid !== 1'b1 || {cmd_wr, cmd_addr, cmd_wdata} !== pay) begin
                    bad++;
                    $display("FAIL rnd_payload[%0d]: got %0b %0b %h %h want 1 %h", n, cmd_valid, cmd_wr, cmd_addr, cmd_wdata, pay);
                end
            end
            idle(3);
            got = (n_par - s_par) * 1 + (n_cmd - s_cmd) * 2 + (n_chk - s_chk) * 3 + (n_acc - s_acc) * 10;
            if (got !== (kind == 0 ? 10 : kind) || n_tmo != s_tmo || n_ovf != s_ovf) begin
                bad++;
                $display("FAIL rnd_outcome[%0d]: got code %0d want %0d", n, got, kind == 0 ? 10 : kind);
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rnd_frames: got %0d bad frames want 0", bad); end
        cmd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_bad_chk();
        test_bad_cmd_parity();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
